cmp_tally: RTL and testbench

Windowed result accumulator that sits directly downstream of the 2-bit magnitude comparator and consumes its one-hot `lt`/`eq`/`grt` flags.

- Collects `WINDOW` comparison results over a valid/ready handshake.
- Counts each outcome, flags malformed (non-one-hot) results, then presents a summary with a dominance verdict.
- Holds the summary until a downstream consumer accepts it, then starts the next window.

---
 rtl/cmp_tally.sv | 177 +++++++++++++++++
 tb/tb_cmp_tally.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_tally.sv
// rtl/cmp_tally.sv - windowed tally of one-hot comparator results with dominance verdict
// Optional feature macro: CMP_TALLY_STREAK_EN (adds max_streak output and run tracking)

module cmp_tally #(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lt,
    input  logic             eq,
    input  logic             grt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] grt_cnt,
    output logic [1:0]       verdict,
`ifdef CMP_TALLY_STREAK_EN
    output logic             err,
    output logic [CNT_W-1:0] max_streak
`else
    output logic             err
`endif
);

    localparam logic S_COLLECT = 1'b0;
    localparam logic S_REPORT  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    localparam logic [1:0] V_EQ  = 2'b00;
    localparam logic [1:0] V_LT  = 2'b01;
    localparam logic [1:0] V_GRT = 2'b10;
    localparam logic [1:0] V_TIE = 2'b11;

    logic             r_state;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [CNT_W-1:0] r_grt_cnt;
    logic [1:0]       r_verdict;
    logic             r_err;

    logic             w_accept;
    logic             w_legal;
    logic             w_last;
    logic             w_release;
    logic [CNT_W-1:0] w_lt_nxt;
    logic [CNT_W-1:0] w_eq_nxt;
    logic [CNT_W-1:0] w_grt_nxt;
    logic [1:0]       w_verdict_nxt;

    // Gating with rst_n keeps in_ready low for the whole reset assertion,
    // without needing an extra register that would delay the first accept.
    assign in_ready  = rst_n & (r_state == S_COLLECT);
    assign out_valid = (r_state == S_REPORT);

    assign w_accept  = in_valid & in_ready;
    assign w_legal   = ({lt, eq, grt} == 3'b100) || ({lt, eq, grt} == 3'b010) ||
                       ({lt, eq, grt} == 3'b001);
    assign w_last    = w_accept && (r_idx == LAST_IDX);
    assign w_release = (r_state == S_REPORT) && out_ready;

    // Counts including the sample being accepted now, so the verdict sees the final window
    assign w_lt_nxt  = r_lt_cnt  + CNT_W'(w_accept & w_legal & lt);
    assign w_eq_nxt  = r_eq_cnt  + CNT_W'(w_accept & w_legal & eq);
    assign w_grt_nxt = r_grt_cnt + CNT_W'(w_accept & w_legal & grt);

    // Dominance: a strict winner gets its code, anything else (incl. all-zero) is a tie
    always_comb begin
        w_verdict_nxt = V_TIE;
        if ((w_lt_nxt > w_eq_nxt) && (w_lt_nxt > w_grt_nxt)) begin
            w_verdict_nxt = V_LT;
        end else if ((w_grt_nxt > w_lt_nxt) && (w_grt_nxt > w_eq_nxt)) begin
            w_verdict_nxt = V_GRT;
        end else if ((w_eq_nxt > w_lt_nxt) && (w_eq_nxt > w_grt_nxt)) begin
            w_verdict_nxt = V_EQ;
        end
    end

    // Two-state control: collect WINDOW samples, then hold the report until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else if (r_state == S_COLLECT) begin
            if (w_last) begin
                r_state <= S_REPORT;
            end
        end else if (out_ready) begin
            r_state <= S_COLLECT;
        end
    end

    // Window counters and sticky error; cleared when the report is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_lt_cnt  <= '0;
            r_eq_cnt  <= '0;
            r_grt_cnt <= '0;
            r_err     <= 1'b0;
        end else if (w_release) begin
            r_idx     <= '0;
            r_lt_cnt  <= '0;
            r_eq_cnt  <= '0;
            r_grt_cnt <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_idx     <= r_idx + 1'b1;
            r_lt_cnt  <= w_lt_nxt;
            r_eq_cnt  <= w_eq_nxt;
            r_grt_cnt <= w_grt_nxt;
            if (!w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    // Verdict is captured once, on the accept that completes the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_verdict <= V_EQ;
        end else if (w_last) begin
            r_verdict <= w_verdict_nxt;
        end
    end

    assign lt_cnt  = r_lt_cnt;
    assign eq_cnt  = r_eq_cnt;
    assign grt_cnt = r_grt_cnt;
    assign verdict = r_verdict;
    assign err     = r_err;

`ifdef CMP_TALLY_STREAK_EN
    // Previous-result code: 00 means no run in progress (after reset, clear or malformed)
    localparam logic [1:0] P_NONE = 2'b00;

    logic [1:0]       r_prev;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_max;
    logic [1:0]       w_cur;
    logic [CNT_W-1:0] w_run_nxt;

    assign w_cur     = lt ? 2'b01 : (grt ? 2'b10 : 2'b11);
    assign w_run_nxt = (w_cur == r_prev) ? (r_run + 1'b1) : CNT_W'(1);

    // Run tracking: same legal result extends the run, malformed breaks it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= P_NONE;
            r_run  <= '0;
            r_max  <= '0;
        end else if (w_release) begin
            r_prev <= P_NONE;
            r_run  <= '0;
            r_max  <= '0;
        end else if (w_accept) begin
            if (w_legal) begin
                r_prev <= w_cur;
                r_run  <= w_run_nxt;
                if (w_run_nxt > r_max) begin
                    r_max <= w_run_nxt;
                end
            end else begin
                r_prev <= P_NONE;
                r_run  <= '0;
            end
        end
    end

    assign max_streak = r_max;
`endif

endmodule

// File: tb/tb_cmp_tally.sv
// tb/tb_cmp_tally.sv - directed self-checking bench for cmp_tally (WINDOW=4, CNT_W=4)

module tb_cmp_tally;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       lt;
    logic       eq;
    logic       grt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] lt_cnt;
    logic [3:0] eq_cnt;
    logic [3:0] grt_cnt;
    logic [1:0] verdict;
    logic       err;
`ifdef CMP_TALLY_STREAK_EN
    logic [3:0] max_streak;
`endif

    int n_cmp;
    int n_bad;

    cmp_tally #(.WINDOW(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lt         (lt),
        .eq         (eq),
        .grt        (grt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lt_cnt     (lt_cnt),
        .eq_cnt     (eq_cnt),
        .grt_cnt    (grt_cnt),
        .verdict    (verdict),
`ifdef CMP_TALLY_STREAK_EN
        .err        (err),
        .max_streak (max_streak)
`else
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample on the falling edge; it is consumed on the next rising edge
    task automatic drive(input logic l, input logic e, input logic g);
        @(negedge clk);
        in_valid = 1'b1;
        lt = l;
        eq = e;
        grt = g;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL drive_in_ready: got %b want 1", in_ready);
            n_bad++;
        end
    endtask

    // Idle the input on the next falling edge; report outputs are sampled there
    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        lt = 1'b0;
        eq = 1'b0;
        grt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        lt = 1'b0;
        eq = 1'b0;
        grt = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
            n_bad++;
        end
        n_cmp++;
        if ({out_valid, lt_cnt, eq_cnt, grt_cnt, verdict, err} !== 16'h0) begin
            $display("FAIL reset_outputs: got ov=%b lt=%0d eq=%0d grt=%0d v=%b err=%b want all 0",
                     out_valid, lt_cnt, eq_cnt, grt_cnt, verdict, err);
            n_bad++;
        end
`ifdef CMP_TALLY_STREAK_EN
        n_cmp++;
        if (max_streak !== 4'd0) begin
            $display("FAIL reset_streak: got %0d want 0", max_streak);
            n_bad++;
        end
`endif
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
            n_bad++;
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 1, 0);
        idle();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            $display("FAIL basic_out_valid: got %b want 1", out_valid);
            n_bad++;
        end
        n_cmp++;
        if ({lt_cnt, eq_cnt, grt_cnt} !== {4'd2, 4'd1, 4'd1}) begin
            $display("FAIL basic_counts: got lt=%0d eq=%0d grt=%0d want 2 1 1", lt_cnt, eq_cnt, grt_cnt);
            n_bad++;
        end
        n_cmp++;
        if ({verdict, err} !== {2'b01, 1'b0}) begin
            $display("FAIL basic_verdict_err: got v=%b err=%b want 01 0", verdict, err);
            n_bad++;
        end
`ifdef CMP_TALLY_STREAK_EN
        n_cmp++;
        if (max_streak !== 4'd2) begin
            $display("FAIL basic_streak: got %0d want 2", max_streak);
            n_bad++;
        end
`endif
        n_cmp++;
        if (in_ready !== 1'b0) begin
            $display("FAIL basic_report_in_ready: got %b want 0", in_ready);
            n_bad++;
        end
        idle();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL basic_one_cycle: got ov=%b ir=%b want 0 1", out_valid, in_ready);
            n_bad++;
        end
        n_cmp++;
        if ({lt_cnt, eq_cnt, grt_cnt, err} !== 13'h0) begin
            $display("FAIL basic_cleared: got lt=%0d eq=%0d grt=%0d err=%b want 0", lt_cnt, eq_cnt, grt_cnt, err);
            n_bad++;
        end
    endtask

    task automatic test_tie();
        out_ready = 1'b1;
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(1, 0, 0);
        drive(0, 0, 1);
        idle();
        n_cmp++;
        if ({out_valid, verdict, lt_cnt, eq_cnt, grt_cnt} !== {1'b1, 2'b11, 4'd2, 4'd0, 4'd2}) begin
            $display("FAIL tie: got ov=%b v=%b lt=%0d eq=%0d grt=%0d want 1 11 2 0 2",
                     out_valid, verdict, lt_cnt, eq_cnt, grt_cnt);
            n_bad++;
        end
`ifdef CMP_TALLY_STREAK_EN
        n_cmp++;
        if (max_streak !== 4'd1) begin
            $display("FAIL tie_streak: got %0d want 1", max_streak);
            n_bad++;
        end
`endif
        idle();
    endtask

    task automatic test_malformed();
        out_ready = 1'b1;
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);
        idle();
        n_cmp++;
        if ({out_valid, lt_cnt, eq_cnt, grt_cnt} !== {1'b1, 4'd0, 4'd2, 4'd0}) begin
            $display("FAIL malformed_counts: got ov=%b lt=%0d eq=%0d grt=%0d want 1 0 2 0",
                     out_valid, lt_cnt, eq_cnt, grt_cnt);
            n_bad++;
        end
        n_cmp++;
        if ({err, verdict} !== {1'b1, 2'b00}) begin
            $display("FAIL malformed_err_verdict: got err=%b v=%b want 1 00", err, verdict);
            n_bad++;
        end
`ifdef CMP_TALLY_STREAK_EN
        n_cmp++;
        if (max_streak !== 4'd1) begin
            $display("FAIL malformed_streak: got %0d want 1", max_streak);
            n_bad++;
        end
`endif
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 0);
        drive(0, 0, 1);
        // REPORT is entered here; keep offering a sample that must not be consumed
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            lt = 1'b1;
            eq = 1'b0;
            grt = 1'b0;
            n_cmp++;
            if ({out_valid, in_ready, lt_cnt, grt_cnt, verdict, err} !== {1'b1, 1'b0, 4'd1, 4'd3, 2'b10, 1'b0}) begin
                $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b lt=%0d grt=%0d v=%b err=%b want 1 0 1 3 10 0",
                         i, out_valid, in_ready, lt_cnt, grt_cnt, verdict, err);
                n_bad++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, lt_cnt, eq_cnt, grt_cnt} !== {1'b0, 1'b1, 12'h0}) begin
            $display("FAIL backpressure_release: got ov=%b ir=%b lt=%0d eq=%0d grt=%0d want 0 1 0 0 0",
                     out_valid, in_ready, lt_cnt, eq_cnt, grt_cnt);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid_window();
        out_ready = 1'b1;
        drive(0, 0, 1);
        drive(0, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, lt_cnt, eq_cnt, grt_cnt, verdict, err} !== 17'h0) begin
            $display("FAIL midreset_outputs: got ir=%b ov=%b grt=%0d v=%b err=%b want all 0",
                     in_ready, out_valid, grt_cnt, verdict, err);
            n_bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);
        idle();
        n_cmp++;
        if ({out_valid, grt_cnt} !== {1'b0, 4'd3}) begin
            $display("FAIL midreset_partial: got ov=%b grt=%0d want 0 3", out_valid, grt_cnt);
            n_bad++;
        end
        drive(0, 0, 1);
        idle();
        n_cmp++;
        if ({out_valid, grt_cnt, verdict} !== {1'b1, 4'd4, 2'b10}) begin
            $display("FAIL midreset_full: got ov=%b grt=%0d v=%b want 1 4 10", out_valid, grt_cnt, verdict);
            n_bad++;
        end
        idle();
    endtask

    task automatic test_streak_eq();
        out_ready = 1'b1;
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(1, 0, 0);
        idle();
        n_cmp++;
        if ({out_valid, verdict, eq_cnt, lt_cnt} !== {1'b1, 2'b00, 4'd3, 4'd1}) begin
            $display("FAIL streak_eq_verdict: got ov=%b v=%b eq=%0d lt=%0d want 1 00 3 1",
                     out_valid, verdict, eq_cnt, lt_cnt);
            n_bad++;
        end
`ifdef CMP_TALLY_STREAK_EN
        n_cmp++;
        if (max_streak !== 4'd3) begin
            $display("FAIL streak_eq_len: got %0d want 3", max_streak);
            n_bad++;
        end
`endif
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_tie();
        test_malformed();
        test_backpressure();
        test_reset_mid_window();
        test_streak_eq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
